// File: rtl/instr_pack.sv
// Shared instruction-path definitions used by the CPU and the program loader.
package instr_pack;

  // Instruction word and program-counter widths shared by CPU and loader.
  localparam int INSTR_W = 9;
  localparam int PC_W    = 10;

  // Program loader sequencing states.
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_START,
    LD_RUN,
    LD_DONE,
    LD_TIMEOUT
  } ld_state;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams words into instruction memory from address 0,
// holds the CPU in reset during the load, then supervises the run until
// cpu_done or a cycle timeout.
module prog_loader
  import instr_pack::*;
#(
  parameter int IM_SIZE = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic [PC_W-1:0]    load_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  output logic               im_wr_en,
  output logic [PC_W-1:0]    im_wr_addr,
  output logic [INSTR_W-1:0] im_wr_data,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               busy,
  output logic               run_done,
  output logic               timed_out,
  output logic               len_err,
  output logic [31:0]        cycles
);

  localparam logic [PC_W-1:0] IM_SIZE_W = PC_W'(IM_SIZE);
  localparam logic [31:0]     TIMEOUT_W = 32'(TIMEOUT);

  ld_state              state_q;
  logic [PC_W-1:0]      len_q, count_q;
  logic                 in_ready_q, im_wr_en_q, cpu_start_q, busy_q;
  logic                 run_done_q, timed_out_q, len_err_q;
  logic [PC_W-1:0]      im_wr_addr_q;
  logic [INSTR_W-1:0]   im_wr_data_q;
  logic [31:0]          cycles_q;

  logic [PC_W-1:0]      len_d, count_d;
  logic                 len_err_d, xfer;
  logic [31:0]          cycles_d;

  // Clamped load length, next word index and saturating run counter.
  always_comb begin
    len_err_d = (load_len > IM_SIZE_W);
    len_d     = len_err_d ? IM_SIZE_W : load_len;
    count_d   = count_q + 1'b1;
    cycles_d  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    xfer      = in_valid & in_ready_q;
  end

  // Sequencer: load, one START cycle, then supervised run; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      im_wr_en_q   <= 1'b0;
      im_wr_addr_q <= '0;
      im_wr_data_q <= '0;
      cpu_start_q  <= 1'b1;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      len_err_q    <= 1'b0;
      cycles_q     <= '0;
    end else begin
      im_wr_en_q <= 1'b0;
      case (state_q)
        LD_IDLE, LD_DONE, LD_TIMEOUT: begin
          if (load_req) begin
            len_q       <= len_d;
            len_err_q   <= len_err_d;
            run_done_q  <= 1'b0;
            timed_out_q <= 1'b0;
            cycles_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b1;
            cpu_start_q <= 1'b1;
            if (len_d != '0) begin
              state_q    <= LD_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              // Zero length reruns whatever program is already resident.
              state_q <= LD_START;
            end
          end
        end
        LD_LOAD: begin
          if (xfer) begin
            im_wr_en_q   <= 1'b1;
            im_wr_addr_q <= count_q;
            im_wr_data_q <= in_data;
            count_q      <= count_d;
            if (count_d == len_q) begin
              in_ready_q <= 1'b0;
              state_q    <= LD_START;
            end
          end
        end
        LD_START: begin
          // The last write lands during this cycle, before the CPU leaves reset.
          state_q     <= LD_RUN;
          cpu_start_q <= 1'b0;
        end
        LD_RUN: begin
          if (cpu_done) begin
            state_q     <= LD_DONE;
            run_done_q  <= 1'b1;
            cpu_start_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cycles_q <= cycles_d;
            if (cycles_d >= TIMEOUT_W) begin
              state_q     <= LD_TIMEOUT;
              timed_out_q <= 1'b1;
              cpu_start_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= LD_IDLE;
          in_ready_q  <= 1'b0;
          cpu_start_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign im_wr_en   = im_wr_en_q;
  assign im_wr_addr = im_wr_addr_q;
  assign im_wr_data = im_wr_data_q;
  assign cpu_start  = cpu_start_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign timed_out  = timed_out_q;
  assign len_err    = len_err_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/run, gapped input, clamping,
// timeout, zero-length rerun and mid-load reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, load_req, in_valid, cpu_done;
  logic [9:0]  load_len;
  logic [8:0]  in_data;
  logic        in_ready, im_wr_en, cpu_start, busy, run_done, timed_out, len_err;
  logic [9:0]  im_wr_addr;
  logic [8:0]  im_wr_data;
  logic [31:0] cycles;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] wa_log[$];
  logic [8:0] wd_log[$];
  logic [8:0] tbdata[64];

  prog_loader #(.IM_SIZE(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy),
    .run_done(run_done), .timed_out(timed_out), .len_err(len_err),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Write-port monitor: logs every strobed write as it would hit memory.
  always @(posedge clk) begin
    if (im_wr_en) begin
      wa_log.push_back(im_wr_addr);
      wd_log.push_back(im_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Drive tbdata[] words over the handshake, optionally valid every other cycle.
  task automatic feed(input int nwords, input bit gap, input int maxcyc);
    int widx = 0;
    int c = 0;
    while (widx < nwords && c < maxcyc) begin
      in_valid = gap ? (c % 2 == 0) : 1'b1;
      in_data  = tbdata[widx];
      if (in_valid && in_ready) widx++;
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    chk("feed_words", widx, nwords);
  endtask

  task automatic check_log(input string tag, input int n);
    int bad = 0;
    chk({tag, "_nwr"}, wa_log.size(), n);
    for (int i = 0; i < n && i < wa_log.size(); i++)
      if (wa_log[i] !== 10'(i) || wd_log[i] !== tbdata[i]) bad++;
    chk({tag, "_content"}, bad, 0);
  endtask

  task automatic request(input logic [9:0] len);
    load_req = 1'b1;
    load_len = len;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0; load_len = '0;
    in_valid = 1'b0; in_data = '0; cpu_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, load_req coincident with reset is ignored
    load_req = 1'b1; load_len = 10'd3;
    @(negedge clk);
    load_req = 1'b0;
    chk("rst_cpu_start", cpu_start, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {im_wr_en, im_wr_addr, im_wr_data, run_done, timed_out, len_err}, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain load and run: three back-to-back words
    request(10'd3);
    chk("t1_ready_up", in_ready, 1);
    chk("t1_busy", busy, 1);
    in_valid = 1'b1; in_data = 9'h1A5;
    @(negedge clk);
    chk("t1_wr0", {im_wr_en, im_wr_addr, im_wr_data}, {1'b1, 10'd0, 9'h1A5});
    in_data = 9'h000;
    @(negedge clk);
    chk("t1_wr1", {im_wr_en, im_wr_addr, im_wr_data}, {1'b1, 10'd1, 9'h000});
    in_data = 9'h1FF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_wr2", {im_wr_en, im_wr_addr, im_wr_data}, {1'b1, 10'd2, 9'h1FF});
    chk("t1_start_ready", in_ready, 0);
    chk("t1_start_cpu", cpu_start, 1);
    @(negedge clk);
    chk("t1_run_cpu", cpu_start, 0);
    chk("t1_run_nowr", im_wr_en, 0);
    repeat (10) @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    chk("t1_cycles", cycles, 10);
    chk("t1_run_done", run_done, 1);
    chk("t1_done_cpu", {cpu_start, busy, timed_out}, {1'b1, 1'b0, 1'b0});

    // Rerun without reload; cpu_done stays high from the previous run
    wa_log.delete(); wd_log.delete();
    @(negedge clk);
    request(10'd0);
    chk("rr_start", {cpu_start, busy, in_ready, run_done, timed_out}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rr_cycles_clr", cycles, 0);
    @(negedge clk);
    chk("rr_run", {cpu_start, run_done}, {1'b0, 1'b0});
    @(negedge clk);
    chk("rr_done", {run_done, cpu_start, busy}, {1'b1, 1'b1, 1'b0});
    chk("rr_cycles", cycles, 0);
    chk("rr_nowr", wa_log.size(), 0);
    cpu_done = 1'b0;

    // Input gaps: four words with in_valid every other cycle
    for (int i = 0; i < 64; i++) tbdata[i] = 9'(9'h0C0 + i);
    wa_log.delete(); wd_log.delete();
    request(10'd4);
    feed(4, 1'b1, 20);
    chk("gap_start_wr", {im_wr_en, im_wr_addr, in_ready}, {1'b1, 10'd3, 1'b0});
    @(negedge clk);
    check_log("gap", 4);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    chk("gap_done", run_done, 1);

    // Clamped length 100 -> 64, then timeout
    for (int i = 0; i < 64; i++) tbdata[i] = 9'(i * 7) ^ 9'h155;
    wa_log.delete(); wd_log.delete();
    request(10'd100);
    chk("clamp_len_err", len_err, 1);
    feed(64, 1'b0, 80);
    chk("clamp_ready_low", in_ready, 0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_log("clamp", 64);
    for (int i = 0; i < 40 && !timed_out; i++) @(negedge clk);
    chk("to_timed_out", timed_out, 1);
    chk("to_cycles", cycles, 16);
    chk("to_flags", {cpu_start, run_done, busy, len_err}, {1'b1, 1'b0, 1'b0, 1'b1});

    // Mid-load reset after two of five words
    wa_log.delete(); wd_log.delete();
    request(10'd5);
    feed(2, 1'b0, 10);
    in_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("mr_ready", in_ready, 0);
    chk("mr_wr", {im_wr_en, im_wr_addr, im_wr_data}, 0);
    chk("mr_flags", {cpu_start, busy, len_err, timed_out, run_done}, {1'b1, 4'b0});
    chk("mr_cycles", cycles, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check_log("mr_partial", 2);
    for (int i = 0; i < 64; i++) tbdata[i] = 9'(9'h1E0 - i);
    wa_log.delete(); wd_log.delete();
    request(10'd2);
    feed(2, 1'b0, 10);
    @(negedge clk);
    check_log("mr_reload", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
